// File: rtl/apu_fetch_arbiter_pkg.sv
// Shared APU fetch-arbiter types: FSM state encoding and default channel count.
package apu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        ACK
    } fetch_state_t;

    localparam int APU_CHANNELS = 8;

endpackage

// File: rtl/apu_fetch_arbiter_if.sv
// Channel-array and sample-memory signals of the fetch arbiter.
// Memory handshake: a read is accepted on a cycle with mem_req && mem_ready; exactly one
// mem_valid pulse returns its data later. Channels hold ch_req until their ch_ack pulse.
interface apu_fetch_arbiter_if
    import apu_pkg::*;
#(
    parameter int CHANNELS = APU_CHANNELS,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32
);
    logic [CHANNELS-1:0]             ch_req;
    logic [CHANNELS-1:0][ADDR_W-1:0] ch_addr;
    logic [CHANNELS-1:0]             ch_ack;
    logic [DATA_W-1:0]               ch_data;
    logic                            mem_req;
    logic [ADDR_W-1:0]               mem_addr;
    logic                            mem_ready;
    logic                            mem_valid;
    logic [DATA_W-1:0]               mem_rdata;

    // Arbiter side.
    modport master (
        input  ch_req, ch_addr, mem_ready, mem_valid, mem_rdata,
        output ch_ack, ch_data, mem_req, mem_addr
    );

    // Channel array plus memory side.
    modport slave (
        output ch_req, ch_addr, mem_ready, mem_valid, mem_rdata,
        input  ch_ack, ch_data, mem_req, mem_addr
    );
endinterface

// File: rtl/apu_fetch_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester at or above last_grant+1, wrapping.
module apu_rr_picker #(
    parameter int CHANNELS = 8
) (
    input  logic [CHANNELS-1:0]         req,
    input  logic [$clog2(CHANNELS)-1:0] last_grant,
    output logic                        any,
    output logic [$clog2(CHANNELS)-1:0] winner
);
    localparam int IDX_W = $clog2(CHANNELS);

    logic [IDX_W:0]        start;
    logic [CHANNELS-1:0]   rot;
    logic [IDX_W-1:0]      off;
    logic                  found;
    logic [IDX_W+1:0]      sum;

    assign any = |req;

    always_comb begin
        start = {1'b0, last_grant} + (IDX_W+1)'(1);
        if (start >= (IDX_W+1)'(CHANNELS)) begin
            start = '0;
        end
        // Rotate so bit 0 is the highest-priority channel, then find the first set bit.
        rot   = CHANNELS'({req, req} >> start);
        off   = '0;
        found = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (!found && rot[i]) begin
                found = 1'b1;
                off   = IDX_W'(i);
            end
        end
        sum = {1'b0, start} + {2'b00, off};
        if (sum >= (IDX_W+2)'(CHANNELS)) begin
            sum = sum - (IDX_W+2)'(CHANNELS);
        end
        winner = sum[IDX_W-1:0];
    end
endmodule

// File: rtl/apu_fetch_arbiter.sv
// Serialises channel sample fetches onto one memory read port, one read outstanding at a time.
module apu_fetch_arbiter
    import apu_pkg::*;
#(
    parameter int CHANNELS = APU_CHANNELS,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32
) (
    input  logic                clk,
    input  logic                rst,
    apu_fetch_arbiter_if.master bus,
    output fetch_state_t        dbg_state
);
    localparam int IDX_W = $clog2(CHANNELS);

    fetch_state_t        state;
    fetch_state_t        state_nxt;
    logic [IDX_W-1:0]    grant_idx;
    logic [IDX_W-1:0]    last_grant;
    logic [IDX_W-1:0]    winner;
    logic                any_req;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   ch_data_q;
    logic [CHANNELS-1:0] ack;

    apu_rr_picker #(.CHANNELS(CHANNELS)) u_picker (
        .req        (bus.ch_req),
        .last_grant (last_grant),
        .any        (any_req),
        .winner     (winner)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // mem_valid outside WAIT and mem_ready outside ISSUE fall through to "hold".
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req)       state_nxt = ISSUE;
            ISSUE:   if (bus.mem_ready) state_nxt = WAIT;
            WAIT:    if (bus.mem_valid) state_nxt = ACK;
            ACK:                        state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            grant_idx  <= '0;
            last_grant <= IDX_W'(CHANNELS - 1);
            mem_addr_q <= '0;
            ch_data_q  <= '0;
        end else begin
            if (state == IDLE && any_req) begin
                grant_idx  <= winner;
                mem_addr_q <= bus.ch_addr[winner];
            end
            if (state == WAIT && bus.mem_valid) begin
                ch_data_q <= bus.mem_rdata;
            end
            if (state == ACK) begin
                last_grant <= grant_idx;
            end
        end
    end

    always_comb begin
        ack = '0;
        if (state == ACK) begin
            ack[grant_idx] = 1'b1;
        end
    end

    assign bus.mem_req  = (state == ISSUE);
    assign bus.mem_addr = mem_addr_q;
    assign bus.ch_data  = ch_data_q;
    assign bus.ch_ack   = ack;
    assign dbg_state    = state;
endmodule

// File: doc/apu_fetch_arbiter.md
# apu_fetch_arbiter

Round-robin arbiter that shares the single sample-memory read port between the APU playback channels. Each channel raises a request with the address of its next sample word. The arbiter serialises these requests into one outstanding memory read at a time and returns the read word with a one-cycle per-channel acknowledge. It sits between the channel array and the APU's memory interface.

## Interface
- `CHANNELS`, default 8: number of requesting channels (2..32).
- `ADDR_W`, default 32: sample address width.
- `DATA_W`, default 32: sample word width.

- `clk`  in  1  system clock.
- `rst`  in  1  reset; synchronous, active-low.
- `ch_req`  in  CHANNELS  per-channel fetch request. Level signal, held until acked.
- `ch_addr`  in  CHANNELS×ADDR_W  per-channel fetch address. Stable while `ch_req` is high.
- `ch_ack`  out  CHANNELS  one-hot, one-cycle pulse: `ch_data` is valid for that channel.
- `ch_data`  out  DATA_W  returned word, broadcast to all channels.
- `mem_req`  out  1  read request to memory.
- `mem_addr`  out  ADDR_W  read address, registered.
- `mem_ready`  in  1  memory accepts the request when `mem_req && mem_ready`.
- `mem_valid`  in  1  read data returned (one pulse per accepted request).
- `mem_rdata`  in  DATA_W  read data.

## Operation
- FSM states: `IDLE`, `ISSUE`, `WAIT`, `ACK`.
- `IDLE`:
  - If any `ch_req` is set, pick a winner, latch `grant_idx`, and latch `mem_addr <= ch_addr[winner]`. Go to `ISSUE`.
  - Otherwise stay in `IDLE`.
- `ISSUE`: `mem_req`=1. On `mem_ready` go to `WAIT`; otherwise hold, with `mem_addr` stable.
- `WAIT`: on `mem_valid`, latch `ch_data <= mem_rdata` and go to `ACK`.
- `ACK`: `ch_ack[grant_idx]`=1 for exactly this cycle. Update `last_grant <= grant_idx`. Go to `IDLE`.
- Round-robin pick: the first index with `ch_req` set, searching upward from `last_grant+1` modulo `CHANNELS`. After reset `last_grant` = `CHANNELS-1`, so channel 0 has top priority first.
- A channel deasserts `ch_req` on the cycle after it sees `ch_ack`. The arbiter re-samples requests only in `IDLE`, so the acked channel is never double-served.
- If a channel drops `ch_req` after being granted, the transaction still completes and `ch_ack` still pulses. The address is the latched value.
- Protocol violations:
  - `mem_valid` outside `WAIT` is ignored; no state change and no ack.
  - `mem_ready` outside `ISSUE` is ignored.
- Exactly one memory read is outstanding at any time.

## Timing
- Reset (`rst`=0 at a rising edge) forces:
  - state `IDLE`;
  - `mem_req`=0, `mem_addr`=0;
  - `ch_ack`=0, `ch_data`=0;
  - `grant_idx`=0, `last_grant`=`CHANNELS-1`.
- Reset mid-transaction abandons it. A `mem_valid` arriving after reset is ignored; the memory side must tolerate the dropped response.
- Latency, with `mem_ready` and `mem_valid` both asserted at the earliest opportunity:
  - request sampled in `IDLE` at cycle 0;
  - `mem_req` high in cycle 1;
  - `mem_valid` accepted in cycle 2;
  - `ch_ack` high in cycle 3.
  - 4 cycles per fetch in total, including the return to `IDLE`.
- Throughput: one fetch per 4 cycles at best, plus memory wait states.
- Outputs `mem_req`, `mem_addr`, `ch_ack` and `ch_data` are all registered or pure state decode; there are no combinational paths from inputs to outputs.

## Structure
- Shared package `apu_pkg` holds:
  - the state enum `fetch_state_t` (`IDLE`, `ISSUE`, `WAIT`, `ACK`);
  - the default channel count constant `APU_CHANNELS` = 8.
- Sub-module `apu_rr_picker`: combinational.
  - Inputs: `CHANNELS`-bit request vector and `last_grant` index.
  - Outputs: `any` flag and `$clog2(CHANNELS)`-bit winner index.
  - Implemented as a double-width rotate plus find-first-set.
- The top level contains the FSM, the address mux/latch and the data register.

## Test plan
- Reset then single request: `ch_req`=8'h04, `ch_addr[2]`=32'h1000, memory zero-wait.
  - Required: `mem_req` in cycle 1 with `mem_addr`=32'h1000.
  - Required: `ch_ack`=8'h04 in cycle 3 with `ch_data`=`mem_rdata`.
- Fairness: all 8 channels request continuously, each dropping its request after its ack and re-raising it 1 cycle later.
  - Required grant order: 0,1,…,7,0; no channel served twice before the others.
- Wrap-around: after a grant to channel 6, requests on channels 1 and 7 only.
  - Required: grant 7 then 1.
- Back-pressure: `mem_ready` low for 5 cycles, then `mem_valid` delayed 3 cycles.
  - Required: `mem_addr` stable throughout `ISSUE`; exactly one `mem_req&&mem_ready` handshake; a single `ch_ack` pulse.
- Reset in `WAIT`: assert `rst`=0 for 1 cycle, then deliver `mem_valid` with 32'hDEAD.
  - Required: no `ch_ack`; `ch_data`=0; FSM idle; the next request is served normally.
- Spurious `mem_valid` in `IDLE`.
  - Required: no state change, `ch_ack`=0.
